// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and constants for the instruction fetch unit.
//   PC_W      : word-address width
//   BUF_DEPTH : entries in the fetch -> decode buffer
//   fetch_state_e : fetch control states
//   pc_legal()    : true when a word address lies inside instruction memory
package fetch_pkg;

   localparam int PC_W      = 16;
   localparam int BUF_DEPTH = 2;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALTED = 2'd1,
      ERR    = 2'd2
   } fetch_state_e;

   function automatic logic pc_legal(input logic [PC_W-1:0] pc, input int unsigned depth);
      return ({{(32-PC_W){1'b0}}, pc} < depth);
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf -- 2-entry FIFO between fetch and decode; entry 0 is always the head.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i_flush             : discard all entries (a same-cycle push is dropped too)
//   i_push, i_instr,
//   i_pc                : write one fetched instruction and its address
//   i_pop               : remove the head entry (caller guarantees not empty)
//   o_valid             : head entry holds a valid instruction
//   o_instr, o_pc       : head entry contents
//   o_count             : current occupancy (0..2)
module fetch_buf
   import fetch_pkg::*;
#(
   parameter int INSTR_W = 16
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_flush,
   input  logic               i_push,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [PC_W-1:0]    i_pc,
   input  logic               i_pop,
   output logic               o_valid,
   output logic [INSTR_W-1:0] o_instr,
   output logic [PC_W-1:0]    o_pc,
   output logic [1:0]         o_count
);

   logic [INSTR_W-1:0] r_instr [BUF_DEPTH];
   logic [PC_W-1:0]    r_pc    [BUF_DEPTH];
   logic [1:0]         r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= 2'd0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_instr[i] <= '0;
            r_pc[i]    <= '0;
         end
      end else if (i_flush) begin
         r_count <= 2'd0;
      end else begin
         case ({i_push, i_pop})
            2'b10: begin
               if (r_count != 2'd2) begin
                  r_instr[r_count[0]] <= i_instr;
                  r_pc[r_count[0]]    <= i_pc;
                  r_count             <= r_count + 2'd1;
               end
            end
            2'b01: begin
               r_instr[0] <= r_instr[1];
               r_pc[0]    <= r_pc[1];
               r_count    <= r_count - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged: the new entry lands behind whatever remains.
               if (r_count == 2'd1) begin
                  r_instr[0] <= i_instr;
                  r_pc[0]    <= i_pc;
               end else begin
                  r_instr[0] <= r_instr[1];
                  r_pc[0]    <= r_pc[1];
                  r_instr[1] <= i_instr;
                  r_pc[1]    <= i_pc;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_valid = (r_count != 2'd0);
   assign o_instr = r_instr[0];
   assign o_pc    = r_pc[0];
   assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch -- PC sequencing and fetch control feeding a 2-entry decode buffer.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   im_addr, im_rd_en        : request to instruction memory (1-cycle read latency)
//   im_instr                 : memory read data
//   redirect, redirect_pc    : taken branch/jump pulse and its target
//   halt                     : level, suspends new fetches
//   dec_valid, dec_ready     : decode handshake
//   dec_instr, dec_pc        : head instruction and its address
//   addr_err                 : sticky, an out-of-range PC was reached
//
// state  | meaning
// RUN    | fetching sequentially while buffer space allows
// HALTED | no new fetches; buffered/in-flight work still drains
// ERR    | PC left instruction memory; waits for redirect to a legal target
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC   = 16'h0000,
   parameter int unsigned     IMEM_DEPTH = 2048,
   parameter int              INSTR_W    = 16
)(
   input  logic               clk,
   input  logic               rst,
   output logic [PC_W-1:0]    im_addr,
   output logic               im_rd_en,
   input  logic [INSTR_W-1:0] im_instr,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   input  logic               halt,
   output logic               dec_valid,
   input  logic               dec_ready,
   output logic [INSTR_W-1:0] dec_instr,
   output logic [PC_W-1:0]    dec_pc,
   output logic               addr_err
);

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   fetch_state_e    r_state;
   fetch_state_e    w_state_nxt;
   logic [PC_W-1:0] r_pc;
   logic            r_inflight;
   logic [PC_W-1:0] r_inflight_pc;
   logic            r_addr_err;

   logic            w_issue;
   logic            w_push;
   logic            w_pop;
   logic [1:0]      w_count;
   logic [2:0]      w_occ;
   logic            w_pc_ok;

   assign w_pc_ok = pc_legal(r_pc, IMEM_DEPTH);
   assign w_pop   = dec_valid & dec_ready;
   // An in-flight response arriving during a redirect belongs to the old path.
   assign w_push  = r_inflight & ~redirect;

   // Occupancy counts the head leaving this cycle, so a steady stream with
   // dec_ready held high keeps one fetch issued every cycle.
   assign w_occ   = {1'b0, w_count} - {2'b00, w_pop} + {2'b00, r_inflight};

   assign w_issue = ~rst && (r_state == RUN) && ~redirect && ~halt && w_pc_ok
                    && (w_occ < 3'd2);

   always_comb begin
      w_state_nxt = r_state;
      if (redirect) begin
         if (halt)
            w_state_nxt = HALTED;
         else if (!pc_legal(redirect_pc, IMEM_DEPTH))
            w_state_nxt = ERR;
         else
            w_state_nxt = RUN;
      end else if (!w_pc_ok) begin
         w_state_nxt = ERR;
      end else begin
         case (r_state)
            RUN:     if (halt)  w_state_nxt = HALTED;
            HALTED:  if (!halt) w_state_nxt = RUN;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= RUN;
         r_pc          <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_addr_err    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_issue;
         if (w_issue)
            r_inflight_pc <= r_pc;
         if (redirect)
            r_pc <= redirect_pc;
         else if (w_issue)
            r_pc <= r_pc + PC_ONE;
         if (w_state_nxt == ERR)
            r_addr_err <= 1'b1;
      end
   end

   fetch_buf #(
      .INSTR_W (INSTR_W)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .i_flush (redirect),
      .i_push  (w_push),
      .i_instr (im_instr),
      .i_pc    (r_inflight_pc),
      .i_pop   (w_pop),
      .o_valid (dec_valid),
      .o_instr (dec_instr),
      .o_pc    (dec_pc),
      .o_count (w_count)
   );

   assign im_addr  = r_pc;
   assign im_rd_en = w_issue;
   assign addr_err = r_addr_err;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch -- directed checks of instr_fetch against a 1-cycle-latency memory model.
module tb_instr_fetch;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] im_addr;
   logic        im_rd_en;
   logic [15:0] im_instr = '0;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halt;
   logic        dec_valid;
   logic        dec_ready;
   logic [15:0] dec_instr;
   logic [15:0] dec_pc;
   logic        addr_err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int c0;

   logic [15:0] iss_q [$];
   int          iss_c [$];
   logic [15:0] dl_pc [$];
   logic [15:0] dl_in [$];
   int          dl_c  [$];
   logic [15:0] vis_q [$];
   logic [15:0] cap_addr = '0;

   instr_fetch #(
      .RESET_PC   (16'h0000),
      .IMEM_DEPTH (2048),
      .INSTR_W    (16)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .im_addr     (im_addr),
      .im_rd_en    (im_rd_en),
      .im_instr    (im_instr),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .dec_valid   (dec_valid),
      .dec_ready   (dec_ready),
      .dec_instr   (dec_instr),
      .dec_pc      (dec_pc),
      .addr_err    (addr_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] mem_f(input logic [15:0] a);
      return a ^ 16'hC3A5;
   endfunction

   // Memory: captures address on the falling edge, data valid after the next rising edge.
   always @(negedge clk) if (im_rd_en) cap_addr <= im_addr;
   always @(posedge clk) im_instr <= mem_f(cap_addr);

   always @(negedge clk) begin
      if (im_rd_en) begin
         iss_q.push_back(im_addr);
         iss_c.push_back(cyc);
      end
      if (dec_valid && dec_ready) begin
         dl_pc.push_back(dec_pc);
         dl_in.push_back(dec_instr);
         dl_c.push_back(cyc);
      end
      if (dec_valid) vis_q.push_back(dec_pc);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      iss_q.delete(); iss_c.delete();
      dl_pc.delete(); dl_in.delete(); dl_c.delete();
      vis_q.delete();
   endtask

   task automatic do_reset(input logic rdy);
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0; dec_ready = rdy;
      tick(2);
      clear_logs();
      rst = 1'b0;
      c0 = cyc;
   endtask

   task automatic test_reset();
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0; dec_ready = 1'b1;
      tick(3);
      n_checks++;
      if (im_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", im_rd_en); end
      n_checks++;
      if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
      n_checks++;
      if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
      n_checks++;
      if (dec_instr !== 16'h0 || dec_pc !== 16'h0) begin
         n_fail++; $display("FAIL reset_dec_data: got instr %h pc %h expected 0 0", dec_instr, dec_pc);
      end
      n_checks++;
      if (im_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h expected 0000", im_addr); end
   endtask

   task automatic test_stream();
      do_reset(1'b1);
      tick(10);
      n_checks++;
      if (iss_q.size() < 8) begin
         n_fail++; $display("FAIL stream_issue_count: got %0d expected >=8", iss_q.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (iss_q[i] !== 16'(i) || iss_c[i] != c0 + i) begin
               n_fail++;
               $display("FAIL stream_issue[%0d]: got addr %h cyc %0d expected addr %h cyc %0d",
                        i, iss_q[i], iss_c[i] - c0, 16'(i), i);
            end
         end
      end
      n_checks++;
      if (dl_pc.size() != 8) begin
         n_fail++; $display("FAIL stream_deliver_count: got %0d expected 8", dl_pc.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (dl_pc[i] !== 16'(i) || dl_in[i] !== mem_f(16'(i)) || dl_c[i] != c0 + 2 + i) begin
               n_fail++;
               $display("FAIL stream_deliver[%0d]: got pc %h instr %h cyc %0d expected pc %h instr %h cyc %0d",
                        i, dl_pc[i], dl_in[i], dl_c[i] - c0, 16'(i), mem_f(16'(i)), i + 2);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset(1'b0);
      tick(5);
      n_checks++;
      if (iss_q.size() != 2) begin
         n_fail++; $display("FAIL bp_outstanding: got %0d fetches expected 2", iss_q.size());
      end
      n_checks++;
      if (dec_valid !== 1'b1 || dec_pc !== 16'h0000) begin
         n_fail++; $display("FAIL bp_head: got valid %b pc %h expected 1 0000", dec_valid, dec_pc);
      end
      dec_ready = 1'b1;
      tick(6);
      n_checks++;
      if (iss_q.size() < 3 || iss_c[2] != c0 + 5) begin
         n_fail++; $display("FAIL bp_resume_issue: got %0d fetches expected third fetch at cycle 5", iss_q.size());
      end
      n_checks++;
      if (dl_pc.size() != 6) begin
         n_fail++; $display("FAIL bp_deliver_count: got %0d expected 6", dl_pc.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (dl_pc[i] !== 16'(i) || dl_in[i] !== mem_f(16'(i))) begin
               n_fail++;
               $display("FAIL bp_order[%0d]: got pc %h instr %h expected pc %h instr %h",
                        i, dl_pc[i], dl_in[i], 16'(i), mem_f(16'(i)));
            end
         end
      end
   endtask

   task automatic test_redirect_full();
      int cr;
      int stale;
      do_reset(1'b0);
      tick(4);
      redirect = 1'b1; redirect_pc = 16'h0100;
      tick(1);
      redirect = 1'b0; dec_ready = 1'b1;
      clear_logs();
      cr = cyc;
      n_checks++;
      if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got dec_valid %b expected 0", dec_valid); end
      tick(8);
      n_checks++;
      if (iss_q.size() == 0 || iss_q[0] !== 16'h0100 || iss_c[0] != cr) begin
         n_fail++; $display("FAIL redir_first_fetch: got %0d fetches expected 0100 at first cycle", iss_q.size());
      end
      stale = 0;
      foreach (vis_q[i]) if (vis_q[i] < 16'h0100) stale++;
      n_checks++;
      if (stale != 0) begin n_fail++; $display("FAIL redir_stale_visible: got %0d stale entries expected 0", stale); end
      n_checks++;
      if (dl_pc.size() < 5) begin
         n_fail++; $display("FAIL redir_deliver_count: got %0d expected >=5", dl_pc.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (dl_pc[i] !== 16'h0100 + 16'(i)) begin
               n_fail++; $display("FAIL redir_deliver[%0d]: got %h expected %h", i, dl_pc[i], 16'h0100 + 16'(i));
            end
         end
      end
   endtask

   task automatic test_redirect_halt();
      int ch;
      bit found;
      do_reset(1'b1);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (im_rd_en && im_addr == 16'h0005) found = 1'b1;
         else tick(1);
      end
      n_checks++;
      if (!found) begin n_fail++; $display("FAIL rh_reach_pc5: got timeout expected fetch of 0005"); end
      redirect = 1'b1; redirect_pc = 16'h0040; halt = 1'b1;
      tick(1);
      redirect = 1'b0;
      clear_logs();
      tick(4);
      n_checks++;
      if (iss_q.size() != 0) begin n_fail++; $display("FAIL rh_no_fetch: got %0d fetches expected 0", iss_q.size()); end
      n_checks++;
      if (u_dut.r_state !== HALTED || im_addr !== 16'h0040) begin
         n_fail++; $display("FAIL rh_halted: got state %0d pc %h expected %0d 0040", u_dut.r_state, im_addr, HALTED);
      end
      halt = 1'b0;
      clear_logs();
      ch = cyc;
      tick(5);
      n_checks++;
      if (iss_q.size() == 0 || iss_q[0] !== 16'h0040 || iss_c[0] != ch + 1) begin
         n_fail++; $display("FAIL rh_resume: got %0d fetches expected 0040 one cycle after release", iss_q.size());
      end
      n_checks++;
      if (dl_pc.size() == 0 || dl_pc[0] !== 16'h0040) begin
         n_fail++; $display("FAIL rh_first_deliver: got %0d deliveries expected first pc 0040", dl_pc.size());
      end
   endtask

   task automatic test_err();
      int cr;
      do_reset(1'b1);
      tick(3);
      n_checks++;
      if (addr_err !== 1'b0) begin n_fail++; $display("FAIL err_clear_before: got %b expected 0", addr_err); end
      redirect = 1'b1; redirect_pc = 16'h07FF;
      tick(1);
      redirect = 1'b0;
      clear_logs();
      tick(6);
      n_checks++;
      if (iss_q.size() != 1 || iss_q[0] !== 16'h07FF) begin
         n_fail++; $display("FAIL err_fetches: got %0d fetches expected only 07FF", iss_q.size());
      end
      n_checks++;
      if (addr_err !== 1'b1 || u_dut.r_state !== ERR) begin
         n_fail++; $display("FAIL err_entered: got addr_err %b state %0d expected 1 %0d", addr_err, u_dut.r_state, ERR);
      end
      n_checks++;
      if (dl_pc.size() != 1 || dl_pc[0] !== 16'h07FF || dl_in[0] !== mem_f(16'h07FF)) begin
         n_fail++; $display("FAIL err_last_deliver: got %0d deliveries expected one of pc 07FF", dl_pc.size());
      end
      redirect = 1'b1; redirect_pc = 16'h0000;
      tick(1);
      redirect = 1'b0;
      clear_logs();
      cr = cyc;
      tick(4);
      n_checks++;
      if (iss_q.size() == 0 || iss_q[0] !== 16'h0000 || iss_c[0] != cr) begin
         n_fail++; $display("FAIL err_recover: got %0d fetches expected 0000 at first cycle", iss_q.size());
      end
      n_checks++;
      if (addr_err !== 1'b1 || u_dut.r_state !== RUN) begin
         n_fail++; $display("FAIL err_sticky: got addr_err %b state %0d expected 1 %0d", addr_err, u_dut.r_state, RUN);
      end
   endtask

   task automatic test_reset_midflight();
      do_reset(1'b1);
      tick(3);
      n_checks++;
      if (im_rd_en !== 1'b1) begin n_fail++; $display("FAIL mr_precond: got rd_en %b expected 1", im_rd_en); end
      tick(1);
      rst = 1'b1;
      #1;
      n_checks++;
      if (im_rd_en !== 1'b0) begin n_fail++; $display("FAIL mr_rd_en_in_reset: got %b expected 0", im_rd_en); end
      tick(1);
      rst = 1'b0;
      clear_logs();
      c0 = cyc;
      n_checks++;
      if (dec_valid !== 1'b0 || dec_pc !== 16'h0 || dec_instr !== 16'h0) begin
         n_fail++; $display("FAIL mr_cleared: got valid %b pc %h instr %h expected 0 0 0", dec_valid, dec_pc, dec_instr);
      end
      tick(1);
      n_checks++;
      if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL mr_no_stale: got dec_valid %b expected 0", dec_valid); end
      tick(3);
      n_checks++;
      if (iss_q.size() == 0 || iss_q[0] !== 16'h0000 || iss_c[0] != c0) begin
         n_fail++; $display("FAIL mr_first_fetch: got %0d fetches expected 0000 at first cycle", iss_q.size());
      end
      n_checks++;
      if (dl_pc.size() == 0 || dl_pc[0] !== 16'h0000 || dl_c[0] != c0 + 2) begin
         n_fail++; $display("FAIL mr_first_deliver: got %0d deliveries expected pc 0000 at cycle 2", dl_pc.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_full();
      test_redirect_halt();
      test_err();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, meaning the first word address fetched after reset.
REQ-002 The block SHALL have parameter IMEM_DEPTH, default 2048, meaning the number of valid instruction words; addresses >= IMEM_DEPTH are illegal.
REQ-003 The block SHALL have parameter INSTR_W, default 16, meaning the width of the instruction word returned by instruction memory.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 im_addr  output  16  word address to instruction memory.
REQ-007 im_rd_en  output  1  read request; memory captures im_addr on the falling edge of the same cycle.
REQ-008 im_instr  input  INSTR_W  memory read data, valid at the rising edge following an im_rd_en cycle.
REQ-009 redirect  input  1  branch/jump taken; single-cycle pulse.
REQ-010 redirect_pc  input  16  target word address, sampled when redirect=1.
REQ-011 halt  input  1  level; stop issuing new fetches while high.
REQ-012 dec_valid  output  1  dec_instr/dec_pc hold a valid fetched instruction.
REQ-013 dec_ready  input  1  decode accepts; transfer occurs when dec_valid & dec_ready at a rising edge.
REQ-014 dec_instr  output  INSTR_W  fetched instruction at the head of the buffer.
REQ-015 dec_pc  output  16  address from which dec_instr was fetched.
REQ-016 addr_err  output  1  sticky flag; an illegal address was reached.

Function
REQ-017 The PC SHALL be word-addressed and SHALL advance by exactly 1 per issued fetch; 16-bit arithmetic.
REQ-018 States SHALL be RUN, HALTED, ERR. RUN->HALTED when halt=1. HALTED->RUN when halt=0. Any->ERR when the PC to issue is >= IMEM_DEPTH. ERR->RUN only on redirect to a legal target.
REQ-019 A fetch SHALL be issued (im_rd_en=1, im_addr=PC) in a cycle only when state=RUN, redirect=0, and (buffer occupancy + in-flight count) < 2.
REQ-020 Read latency SHALL be 1 cycle: data for a fetch issued in cycle N SHALL be written into the buffer at the rising edge ending cycle N+1 with its issuing PC.
REQ-021 The output buffer SHALL hold 2 entries, FIFO order; dec_* SHALL be driven from the head entry only; dec_valid SHALL be registered state, not combinational on inputs.
REQ-022 Full-throughput case: with dec_ready held 1, one instruction per cycle SHALL be delivered after the initial latency.
REQ-023 Push and pop in the same cycle SHALL leave occupancy unchanged; a pop with the buffer empty SHALL not occur.
REQ-024 On redirect: a handshake in that cycle is honoured; all remaining buffer entries and any in-flight response SHALL be discarded; the PC SHALL load redirect_pc; the first fetch to redirect_pc SHALL issue in the next cycle.
REQ-025 redirect SHALL take priority over halt for PC update; if halt is also 1, the state SHALL be HALTED with PC=redirect_pc.
REQ-026 halt SHALL not discard in-flight or buffered instructions; they remain deliverable.
REQ-027 The wrap from 16'hFFFF SHALL not occur in legal operation; reaching an address >= IMEM_DEPTH SHALL enter ERR, set addr_err, and issue nothing.

Reset
REQ-028 While rst=1: PC=RESET_PC, state=RUN, buffer empty, in-flight cleared, dec_valid=0, im_rd_en=0, addr_err=0, dec_instr=0, dec_pc=0.
REQ-029 rst asserted mid-operation SHALL discard all buffered and in-flight instructions; the first fetch of RESET_PC SHALL issue in the first cycle after rst deasserts.

Structure
REQ-030 Package fetch_pkg SHALL hold the state enum, PC_W=16, and BUF_DEPTH=2.
REQ-031 The 2-entry buffer SHALL be a sub-module fetch_buf with a flush input; pc/instr/state logic SHALL stay in instr_fetch.

Verification
REQ-032 Reset release, dec_ready=1 -> im_addr 0,1,2,... on consecutive cycles; dec_pc 0,1,2,... delivered one per cycle starting cycle 2.
REQ-033 dec_ready=0 for 5 cycles -> at most 2 fetches outstanding; no further im_rd_en; the buffered instructions for pc 0 and 1 are delivered in order on release; nothing dropped or duplicated.
REQ-034 Redirect to 16'h0100 while the buffer is full -> next dec_pc after the redirect is 16'h0100; the stale entries are never seen with dec_valid=1.
REQ-035 Redirect and halt asserted together at PC 5 (target 16'h0040) -> state HALTED, no im_rd_en; on halt=0 the first im_addr is 16'h0040.
REQ-036 Redirect to 16'h07FF (IMEM_DEPTH=2048) -> 16'h07FF is fetched, then ERR with addr_err=1 and no fetch of 16'h0800; a later redirect to 16'h0000 resumes with addr_err still 1.
REQ-037 rst pulse while a fetch is in flight -> no dec_valid for the pre-reset fetch; the next im_addr is RESET_PC.
